// File: rtl/btn_toggle.sv
//==============================================================================
// Module      : btn_toggle
// Description : Debounced push-button toggle. Each accepted press inverts OUT,
//               emits a one-cycle PULSE and advances a wrapping 8-bit press
//               counter. A press or release is accepted only after the
//               synchronized button level has held for DEBOUNCE_CYCLES edges.
//               Optional macro BTN_ACTIVE_LOW_EN: button pin is active-low.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_toggle #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_IN,
    output logic       OUT,
    output logic       PULSE,
    output logic [7:0] PRESS_CNT
);

    // Terminal value of the debounce counter.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_ACTIVE_LOW_EN
    // The raw pin idles high, so the synchronizer holds the raw level and
    // resets to 1; the pressed sense is recovered at its output. Reset
    // therefore never looks like a press.
    localparam logic C_SYNC_RST = 1'b1;
`else
    localparam logic C_SYNC_RST = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             w_sync;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_q,       out_d;
    logic             pulse_q,     pulse_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= C_SYNC_RST;
            sync2_q <= C_SYNC_RST;
        end else begin
            sync1_q <= BTN_IN;
            sync2_q <= sync1_q;
        end
    end

`ifdef BTN_ACTIVE_LOW_EN
    assign w_sync = ~sync2_q;
`else
    assign w_sync = sync2_q;
`endif

    // Next-state logic: debounce FSM, toggle, strobe and press counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        pulse_d     = 1'b0;
        press_cnt_d = press_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_sync) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_sync) begin
                    // Bounce before the press was qualified: drop it.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d     = S_HELD;
                    cnt_d       = '0;
                    out_d       = ~out_q;
                    pulse_d     = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                // Holding the button never retoggles.
                if (!w_sync) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_sync) begin
                    // Release bounce: still held, no event.
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_MAX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            pulse_q     <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            pulse_q     <= pulse_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign OUT       = out_q;
    assign PULSE     = pulse_q;
    assign PRESS_CNT = press_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_toggle.sv
//==============================================================================
// Module      : tb_btn_toggle
// Description : Self-checking bench for btn_toggle (DEBOUNCE_CYCLES=4,
//               CNT_W=3, active-high build). Reference model treats the
//               debouncer as "the synchronized level must differ from the
//               accepted level for DEBOUNCE_CYCLES+1 consecutive edges".
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_btn_toggle;

    localparam int DEB = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BTN_IN;
    logic       OUT;
    logic       PULSE;
    logic [7:0] PRESS_CNT;

    int total = 0;
    int bad   = 0;
    int pulses_seen = 0;

    btn_toggle #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_IN   (BTN_IN),
        .OUT      (OUT),
        .PULSE    (PULSE),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: two-edge synchronizer delay, then a stable-run counter.
    logic m_s1, m_s2, m_use, m_deb, m_out, m_pulse;
    int   m_run;
    int   m_cnt;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0;
            m_out = 0; m_pulse = 0; m_cnt = 0;
        end else begin
            m_use   = m_s2;
            m_s2    = m_s1;
            m_s1    = BTN_IN;
            m_pulse = 0;
            if (m_use != m_deb) m_run = m_run + 1;
            else                m_run = 0;
            if (m_run == DEB + 1) begin
                m_deb = m_use;
                m_run = 0;
                if (m_deb) begin
                    m_out   = ~m_out;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_pulse = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},   {31'd0, OUT},   {31'd0, m_out});
        chk({tag, ".pulse"}, {31'd0, PULSE}, {31'd0, m_pulse});
        chk({tag, ".cnt"},   {24'd0, PRESS_CNT}, m_cnt);
    endtask

    // One clock with the given button level, then compare against the model.
    task automatic cycle(input logic b, input string tag);
        BTN_IN = b;
        @(posedge CLK);
        #1;
        if (PULSE === 1'b1) pulses_seen++;
        chk_model(tag);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #2;
        chk("rst.out",   {31'd0, OUT},   32'd0);
        chk("rst.pulse", {31'd0, PULSE}, 32'd0);
        chk("rst.cnt",   {24'd0, PRESS_CNT}, 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, "rst_idle");
    endtask

    int p0;
    int lat;

    initial begin
        BTN_IN = 1'b0;
        RST_N  = 1'b0;
        #1;
        // 1: reset and idle
        chk("t1.rst_out", {31'd0, OUT}, 32'd0);
        chk("t1.rst_cnt", {24'd0, PRESS_CNT}, 32'd0);
        #12;
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, "t1");
            chk("t1.out0", {31'd0, OUT}, 32'd0);
        end

        // 2: clean press, toggle at edge k+6, one pulse, release quiet
        p0 = pulses_seen; lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, "t2.hold");
            if (lat == 0 && OUT === 1'b1) lat = i + 1;
        end
        chk("t2.latency_edges", lat, 7);
        for (int i = 0; i < 20; i++) cycle(1'b0, "t2.rel");
        chk("t2.pulses", pulses_seen - p0, 1);
        chk("t2.out", {31'd0, OUT}, 32'd1);
        chk("t2.cnt", {24'd0, PRESS_CNT}, 32'd1);

        // 3: press bounce never qualifies
        do_reset();
        p0 = pulses_seen;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, "t3.b1");
            cycle(1'b0, "t3.b0");
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, "t3.idle");
        chk("t3.pulses", pulses_seen - p0, 0);
        chk("t3.out", {31'd0, OUT}, 32'd0);
        chk("t3.cnt", {24'd0, PRESS_CNT}, 32'd0);

        // 4: release bounce yields exactly one toggle
        do_reset();
        p0 = pulses_seen;
        for (int i = 0; i < 10; i++) cycle(1'b1, "t4.press");
        for (int i = 0; i < 20; i++) cycle(((i / 2) % 2) == 1, "t4.bounce");
        for (int i = 0; i < 15; i++) cycle(1'b0, "t4.rel");
        chk("t4.pulses", pulses_seen - p0, 1);
        chk("t4.out", {31'd0, OUT}, 32'd1);
        chk("t4.cnt", {24'd0, PRESS_CNT}, 32'd1);

        // 5: 256 presses wrap the counter
        do_reset();
        p0 = pulses_seen;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 8; i++) cycle(1'b1, "t5.press");
            for (int i = 0; i < 8; i++) cycle(1'b0, "t5.rel");
            if (n == 254) chk("t5.cnt255", {24'd0, PRESS_CNT}, 32'd255);
        end
        chk("t5.pulses", pulses_seen - p0, 256);
        chk("t5.out", {31'd0, OUT}, 32'd0);
        chk("t5.cnt", {24'd0, PRESS_CNT}, 32'd0);

        // 6: async reset mid-PRESS_WAIT discards event; full latency after
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, "t6.press");
        for (int i = 0; i < 10; i++) cycle(1'b0, "t6.rel");
        chk("t6.pre_out", {31'd0, OUT}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, "t6.pw");
        RST_N = 1'b0;
        #1;
        chk("t6.async_out",   {31'd0, OUT},   32'd0);
        chk("t6.async_pulse", {31'd0, PULSE}, 32'd0);
        chk("t6.async_cnt",   {24'd0, PRESS_CNT}, 32'd0);
        #1;
        RST_N = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, "t6.hold");
            if (lat == 0 && OUT === 1'b1) lat = i + 1;
        end
        chk("t6.latency_edges", lat, 7);
        for (int i = 0; i < 10; i++) cycle(1'b0, "t6.rel2");

        // Random bouncing runs against the model
        do_reset();
        for (int r = 0; r < 400; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) cycle(lvl, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
